// File: rtl/i2c_sniff_pkg.sv
// Shared encodings for the I2C sniffer: receiver/output FSM states and the
// layout of one buffered FIFO entry {first, ack, data[7:0]}.
package i2c_sniff_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_DATA = 2'd1,
    R_ACK  = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    O_IDLE    = 2'd0,
    O_WAIT_HI = 2'd1,
    O_WAIT_LO = 2'd2
  } out_state_t;

  localparam int unsigned ENTRY_W   = 10;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned FIRST_POS = 9;
  localparam int unsigned ACK_POS   = 8;
  localparam int unsigned DATA_LSB  = 0;

endpackage

// File: rtl/i2c_sniff_to_uart_line_filter.sv
// Synchroniser plus stability filter for one raw I2C line.
// Ports: clk, reset (async, active-high), din (raw asynchronous line),
//        dout (filtered line, resets to 1 = bus idle).
// dout only follows the synchronised line once it has held a new value for
// FILTER_LEN consecutive samples, so shorter glitches never reach the FSMs.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with dout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_sniff_to_uart.sv
// Passive I2C bus monitor feeding a UART transmitter.
// Ports: clk, reset (async, active-high); scl/sda raw bus lines;
//        busy from the UART; tx_data/tx_ack/tx_first describe the presented
//        byte, tx_trigger is a one-cycle start pulse; overflow is sticky and
//        set when a received byte was dropped because the FIFO was full.
module i2c_sniff_to_uart
  import i2c_sniff_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned FILTER_LEN   = 3,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  input  logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_trigger,
  output logic       tx_ack,
  output logic       tx_first,
  output logic       overflow
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned TW   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise_c, start_c, stop_c;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .din(scl), .dout(scl_f));
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .din(sda), .dout(sda_f));

  // one-cycle delayed copies for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise_c = scl_f & ~scl_d;
  assign start_c    = scl_f & sda_d & ~sda_f;
  assign stop_c     = scl_f & ~sda_d & sda_f;

  // ---------------- receiver ----------------
  rx_state_t    rx_state, rx_state_nxt;
  logic [2:0]   bit_cnt, bit_cnt_nxt;
  logic [7:0]   shift, shift_nxt;
  logic         first, first_nxt;
  logic         push_c;
  logic [ENTRY_W-1:0] push_entry_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= R_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      first    <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      first    <= first_nxt;
    end
  end

  // START/STOP override any partial byte; bits are only taken on scl rise
  always_comb begin
    rx_state_nxt = rx_state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    first_nxt    = first;
    push_c       = 1'b0;
    if (start_c) begin
      rx_state_nxt = R_DATA;
      bit_cnt_nxt  = '0;
      shift_nxt    = '0;
      first_nxt    = 1'b1;
    end else if (stop_c) begin
      rx_state_nxt = R_IDLE;
    end else if (scl_rise_c) begin
      case (rx_state)
        R_DATA: begin
          shift_nxt   = {shift[6:0], sda_f};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rx_state_nxt = R_ACK;
        end
        R_ACK: begin
          push_c       = 1'b1;
          first_nxt    = 1'b0;
          bit_cnt_nxt  = '0;
          rx_state_nxt = R_DATA;
        end
        default: ;
      endcase
    end
  end

  assign push_entry_c = {first, ~sda_f, shift};

  // ---------------- FIFO ----------------
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CNTW-1:0]    count;
  logic               full_c, empty_c, wr_en_c, pop_c;
  logic [ENTRY_W-1:0] head_c;

  assign full_c  = (count == CNTW'(FIFO_DEPTH));
  assign empty_c = (count == '0);
  // a simultaneous pop frees a slot, so push still succeeds when full
  assign wr_en_c = push_c & (~full_c | pop_c);
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= push_entry_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en_c, pop_c})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: ;
      endcase
      if (push_c && full_c && !pop_c) overflow <= 1'b1;
    end
  end

  // ---------------- output FSM ----------------
  out_state_t    out_state, out_state_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state  <= O_IDLE;
      tmo_cnt    <= '0;
      tx_trigger <= 1'b0;
      tx_data    <= '0;
      tx_ack     <= 1'b0;
      tx_first   <= 1'b0;
    end else begin
      out_state  <= out_state_nxt;
      tmo_cnt    <= tmo_nxt;
      tx_trigger <= pop_c;
      if (pop_c) begin
        tx_data  <= head_c[DATA_LSB +: DATA_W];
        tx_ack   <= head_c[ACK_POS];
        tx_first <= head_c[FIRST_POS];
      end
    end
  end

  // a UART that never acknowledges costs one byte, never a stall
  always_comb begin
    out_state_nxt = out_state;
    tmo_nxt       = tmo_cnt;
    pop_c         = 1'b0;
    case (out_state)
      O_IDLE: begin
        if (!empty_c && !busy) begin
          pop_c         = 1'b1;
          tmo_nxt       = '0;
          out_state_nxt = O_WAIT_HI;
        end
      end
      O_WAIT_HI: begin
        if (busy) begin
          out_state_nxt = O_WAIT_LO;
        end else if (tmo_cnt == TW'(BUSY_TIMEOUT - 1)) begin
          out_state_nxt = O_IDLE;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
      O_WAIT_LO: begin
        if (!busy) out_state_nxt = O_IDLE;
      end
      default: out_state_nxt = O_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_sniff_to_uart.sv
// Directed bench for i2c_sniff_to_uart: drives I2C transfers, models the
// UART busy handshake and checks every presented byte against hand values.
module tb_i2c_sniff_to_uart;

  localparam int Q = 60;  // quarter of a 240-clk I2C bit period

  logic       clk = 1'b0;
  logic       reset, scl, sda, busy;
  logic [7:0] tx_data;
  logic       tx_trigger, tx_ack, tx_first, overflow;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [9:0] trig_q[$];
  int         trig_t[$];

  bit force_busy   = 1'b0;
  bit uart_respond = 1'b1;
  int busy_len     = 30;

  always #10 clk = ~clk;

  i2c_sniff_to_uart dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .busy(busy),
    .tx_data(tx_data), .tx_trigger(tx_trigger), .tx_ack(tx_ack),
    .tx_first(tx_first), .overflow(overflow));

  always @(posedge clk) cyc <= cyc + 1;

  // record every presented byte as {first, ack, data}
  always @(negedge clk) begin
    if (tx_trigger === 1'b1) begin
      trig_q.push_back({tx_first, tx_ack, tx_data});
      trig_t.push_back(cyc);
    end
  end

  // UART model: busy for busy_len cycles per trigger, or forced/never
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (force_busy) begin
        busy = 1'b1;
      end else if (tx_trigger === 1'b1 && uart_respond) begin
        busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        busy = 1'b0;
      end else begin
        busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ent(input logic f, input logic a, input logic [7:0] d);
    return {f, a, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    sda = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    sda = 1'b1; tick(Q);
  endtask

  // optional glitch of glen cycles on sda in the middle of the scl-high phase
  task automatic i2c_bit(input logic b, input int glen);
    sda = b; tick(Q);
    scl = 1'b1; tick(Q / 2);
    if (glen > 0) begin
      sda = ~b; tick(glen);
      sda = b;
    end
    tick(2 * Q - Q / 2 - glen);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_byte(input logic [7:0] d, input logic ack, input int glen, input int gpos);
    for (int k = 0; k < 8; k++) i2c_bit(d[7-k], (k == gpos) ? glen : 0);
    i2c_bit(~ack, 0);
  endtask

  task automatic wait_trig(input int n, input int budget, input string tag);
    int k = 0;
    while (trig_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(trig_q.size()), 32'(n));
  endtask

  task automatic wait_uart_idle();
    int k = 0;
    while (busy && k < 5000) begin
      tick(1);
      k++;
    end
    chk("uart_idle", 32'(busy), 32'd0);
    trig_q.delete();
    trig_t.delete();
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset = 1'b1; scl = 1'b1; sda = 1'b1;
    tick(5);
    chk("rst_data",  32'(tx_data),    32'd0);
    chk("rst_trig",  32'(tx_trigger), 32'd0);
    chk("rst_ack",   32'(tx_ack),     32'd0);
    chk("rst_first", 32'(tx_first),   32'd0);
    chk("rst_ovf",   32'(overflow),   32'd0);
    reset = 1'b0;
    tick(20);

    // single write: address + data, UART slower than the bus
    busy_len = 2500;
    i2c_start();
    i2c_byte(8'hA0, 1'b1, 0, 0);
    i2c_byte(8'h5A, 1'b1, 0, 0);
    i2c_stop();
    wait_trig(2, 6000, "sw_count");
    chk("sw_byte0", 32'(trig_q[0]), 32'(ent(1'b1, 1'b1, 8'hA0)));
    chk("sw_byte1", 32'(trig_q[1]), 32'(ent(1'b0, 1'b1, 8'h5A)));
    chk("sw_hold_data", 32'(tx_data), 32'h5A);

    // asynchronous reset in the middle of a clock cycle
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_data",  32'(tx_data),    32'd0);
    chk("arst_ack",   32'(tx_ack),     32'd0);
    chk("arst_first", 32'(tx_first),   32'd0);
    chk("arst_trig",  32'(tx_trigger), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n0 = trig_q.size();
    tick(100);
    chk("arst_quiet", 32'(trig_q.size()), 32'(n0));

    // NACK then repeated START
    wait_uart_idle();
    busy_len = 30;
    i2c_start();
    i2c_byte(8'h91, 1'b0, 0, 0);
    i2c_start();
    i2c_byte(8'h90, 1'b1, 0, 0);
    i2c_stop();
    wait_trig(2, 1000, "rs_count");
    chk("rs_nack",  32'(trig_q[0]), 32'(ent(1'b1, 1'b0, 8'h91)));
    chk("rs_first", 32'(trig_q[1]), 32'(ent(1'b1, 1'b1, 8'h90)));

    // 1- and 2-cycle sda glitches while scl high are ignored
    wait_uart_idle();
    i2c_start();
    i2c_byte(8'h11, 1'b1, 0, 0);
    i2c_byte(8'hFF, 1'b1, 1, 0);
    i2c_byte(8'hFF, 1'b1, 2, 3);
    i2c_stop();
    wait_trig(3, 1000, "gl_count");
    chk("gl_byte0", 32'(trig_q[0]), 32'(ent(1'b1, 1'b1, 8'h11)));
    chk("gl_byte1", 32'(trig_q[1]), 32'(ent(1'b0, 1'b1, 8'hFF)));
    chk("gl_byte2", 32'(trig_q[2]), 32'(ent(1'b0, 1'b1, 8'hFF)));

    // 3-cycle glitch is a real START followed by STOP: byte is lost
    wait_uart_idle();
    i2c_start();
    i2c_byte(8'h22, 1'b1, 0, 0);
    i2c_byte(8'hFF, 1'b1, 3, 2);
    i2c_stop();
    tick(500);
    chk("gl3_count", 32'(trig_q.size()), 32'd1);
    chk("gl3_byte0", 32'(trig_q[0]), 32'(ent(1'b1, 1'b1, 8'h22)));

    // STOP after 5 bits discards the partial byte; next transfer is clean
    wait_uart_idle();
    i2c_start();
    i2c_bit(1'b1, 0); i2c_bit(1'b0, 0); i2c_bit(1'b1, 0);
    i2c_bit(1'b1, 0); i2c_bit(1'b0, 0);
    i2c_stop();
    tick(300);
    chk("ab_nopush", 32'(trig_q.size()), 32'd0);
    i2c_start();
    i2c_byte(8'h66, 1'b1, 0, 0);
    i2c_stop();
    wait_trig(1, 500, "ab_count");
    chk("ab_byte", 32'(trig_q[0]), 32'(ent(1'b1, 1'b1, 8'h66)));

    // UART never answers: each entry abandoned after the busy timeout
    wait_uart_idle();
    force_busy = 1'b1;
    tick(2);
    uart_respond = 1'b0;
    i2c_start();
    i2c_byte(8'h33, 1'b1, 0, 0);
    i2c_byte(8'h44, 1'b1, 0, 0);
    i2c_stop();
    chk("to_held", 32'(trig_q.size()), 32'd0);
    force_busy = 1'b0;
    wait_trig(2, 200, "to_count");
    chk("to_byte0", 32'(trig_q[0]), 32'(ent(1'b1, 1'b1, 8'h33)));
    chk("to_byte1", 32'(trig_q[1]), 32'(ent(1'b0, 1'b1, 8'h44)));
    chk("to_gap",   32'(trig_t[1] - trig_t[0]), 32'd17);
    tick(100);
    uart_respond = 1'b1;

    // overflow: 10 bytes into an 8-deep FIFO with the UART held busy
    wait_uart_idle();
    busy_len   = 20;
    force_busy = 1'b1;
    tick(2);
    i2c_start();
    for (int i = 0; i < 10; i++) begin
      i2c_byte(8'h30 + 8'(i), 1'b1, 0, 0);
      if (i == 7) chk("ovf_before", 32'(overflow), 32'd0);
      if (i == 8) chk("ovf_ninth",  32'(overflow), 32'd1);
    end
    i2c_stop();
    chk("ovf_set",  32'(overflow), 32'd1);
    chk("ovf_held", 32'(trig_q.size()), 32'd0);
    force_busy = 1'b0;
    wait_trig(8, 2000, "ovf_drain");
    tick(300);
    chk("ovf_count", 32'(trig_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("ovf_byte%0d", i), 32'(trig_q[i]),
          32'(ent(1'(i == 0), 1'b1, 8'h30 + 8'(i))));
    chk("ovf_sticky", 32'(overflow), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
